gen_prog_delay: RTL

Runtime-programmable, stallable multi-channel delay line with per-sample valid tracking. Each enabled cycle it advances one stage; the output is the input from `dly` enabled cycles earlier, selectable from 0 to MAX_DP without resynthesis. It sits wherever a data path must be time-aligned to a variable-latency sibling path, such as pipeline side-band alignment or debug tap delay, and replaces fixed-depth tick synchronisers where depth must change at run time.

---
 rtl/gen_utils_pkg.sv | 18 +
 rtl/gen_en_dff.sv | 20 ++
 rtl/gen_prog_delay.sv | 89 ++++++++
 3 files changed

// File: rtl/gen_utils_pkg.sv
// Shared helpers for the generic building blocks: ceiling log2 and the width
// of a delay-select field able to encode 0..max_dp.
package gen_utils_pkg;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int dly_width(input int unsigned max_dp);
        return (clog2(max_dp + 1) < 1) ? 1 : clog2(max_dp + 1);
    endfunction

endpackage

// File: rtl/gen_en_dff.sv
// Parameter-width register with synchronous active-high reset, clear and load
// enable. Reset and clear both return the register to zero; clear ignores en.
module gen_en_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/gen_prog_delay.sv
// Runtime-programmable, stallable multi-channel delay line. Output is the
// input from dly enabled cycles earlier; dly = 0 is a combinational bypass.
module gen_prog_delay
    import gen_utils_pkg::*;
#(
    parameter int DW     = 32,
    parameter int CH     = 1,
    parameter int MAX_DP = 8,
    parameter int DLY_W  = dly_width(MAX_DP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [DLY_W-1:0]   dly,
    input  logic               din_vld,
    input  logic [CH*DW-1:0]   din,
    output logic               dout_vld,
    output logic [CH*DW-1:0]   dout,
    output logic               busy
);

    logic [DLY_W-1:0] dly_c;
    logic [DLY_W-1:0] dly_q;
    logic             clr;
    logic [CH*DW-1:0] st_d [MAX_DP];
    logic [MAX_DP-1:0] st_v;

    always_comb begin
        dly_c = (dly > DLY_W'(MAX_DP)) ? DLY_W'(MAX_DP) : dly;
    end

    // A delay change invalidates everything in flight, but only once the line moves.
    assign clr = flush | (en & (dly_c != dly_q));

    gen_en_dff #(.W(DLY_W)) u_dly_q (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (1'b0),
        .d   (dly_c),
        .q   (dly_q)
    );

    for (genvar i = 0; i < MAX_DP; i++) begin : g_stage
        logic [CH*DW-1:0] d_in;
        logic             v_in;

        if (i == 0) begin : g_head
            assign d_in = din;
            assign v_in = din_vld;
        end else begin : g_body
            assign d_in = st_d[i-1];
            assign v_in = st_v[i-1];
        end

        gen_en_dff #(.W(CH*DW)) u_data (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .clr (1'b0),
            .d   (d_in),
            .q   (st_d[i])
        );

        gen_en_dff #(.W(1)) u_vld (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .clr (clr),
            .d   (v_in),
            .q   (st_v[i])
        );
    end

    always_comb begin
        dout     = din;
        dout_vld = din_vld & en;
        busy     = 1'b0;
        for (int unsigned i = 0; i < MAX_DP; i++) begin
            if (dly_c == DLY_W'(i + 1)) begin
                dout     = st_d[i];
                dout_vld = st_v[i];
            end
            if (DLY_W'(i) < dly_c) busy = busy | st_v[i];
        end
    end

endmodule
